// File: rtl/alu_issue_unit.sv
// Issue/writeback stage in front of the ALU: owns an 8-entry register file, drives
// registered ALU operands and writes back the result, multiplier high byte and flags.
module alu_issue_unit #(
   parameter logic [3:0] MUL_FUNC = 4'd4,
   parameter int         REG_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       instr_func,
   input  logic [2:0]       instr_rs1,
   input  logic [2:0]       instr_rs2,
   input  logic [2:0]       instr_rd,
   input  logic             instr_wb,
   input  logic             ld_valid,
   input  logic [2:0]       ld_addr,
   input  logic [REG_W-1:0] ld_data,
   output logic [REG_W-1:0] alu_a,
   output logic [REG_W-1:0] alu_b,
   output logic [3:0]       alu_fsel,
   input  logic [REG_W-1:0] alu_result,
   input  logic [REG_W-1:0] alu_mul_high,
   input  logic [3:0]       alu_sreg,
   output logic [3:0]       sreg,
   output logic             retired,
   input  logic [2:0]       dbg_addr,
   output logic [REG_W-1:0] dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_WB_HI = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [REG_W-1:0] r_rf [8];
   logic [REG_W-1:0] r_alu_a;
   logic [REG_W-1:0] r_alu_b;
   logic [3:0]       r_alu_fsel;
   logic [2:0]       r_rd;
   logic             r_wb;
   logic [REG_W-1:0] r_hold;
   logic [3:0]       r_sreg;
   logic             r_retired;

   logic             w_accept;
   logic             w_is_mul_wb;
   logic             w_wb_en;
   logic [2:0]       w_wb_addr;
   logic [REG_W-1:0] w_wb_data;
   logic             w_retire;
   logic [7:0]       w_rf_we;
   logic [REG_W-1:0] w_rf_wdata [8];

   assign instr_ready = (r_state == S_IDLE) && !ld_valid;
   assign w_accept    = instr_valid && instr_ready;
   // alu_fsel doubles as the latched function code of the in-flight instruction
   assign w_is_mul_wb = r_wb && (r_alu_fsel == MUL_FUNC);

   always_comb begin
      w_state_next = r_state;
      w_wb_en      = 1'b0;
      w_wb_addr    = r_rd;
      w_wb_data    = alu_result;
      w_retire     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_wb_en = r_wb;
            if (w_is_mul_wb) begin
               w_state_next = S_WB_HI;
            end else begin
               w_state_next = S_IDLE;
               w_retire     = 1'b1;
            end
         end
         S_WB_HI: begin
            w_wb_en      = 1'b1;
            w_wb_addr    = r_rd + 3'd1;
            w_wb_data    = r_hold;
            w_retire     = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Writeback has priority over a same-edge load to the same register
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rf_wr
         always_comb begin
            w_rf_we[gi]    = 1'b0;
            w_rf_wdata[gi] = ld_data;
            if (w_wb_en && (w_wb_addr == 3'(gi))) begin
               w_rf_we[gi]    = 1'b1;
               w_rf_wdata[gi] = w_wb_data;
            end else if (ld_valid && (ld_addr == 3'(gi))) begin
               w_rf_we[gi] = 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            r_rf[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (w_rf_we[i]) begin
               r_rf[i] <= w_rf_wdata[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_fsel <= '0;
         r_rd       <= '0;
         r_wb       <= 1'b0;
         r_hold     <= '0;
         r_sreg     <= '0;
         r_retired  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_retired <= w_retire;
         if (w_accept) begin
            r_alu_a    <= r_rf[instr_rs1];
            r_alu_b    <= r_rf[instr_rs2];
            r_alu_fsel <= instr_func;
            r_rd       <= instr_rd;
            r_wb       <= instr_wb;
         end
         if (r_state == S_EXEC) begin
            r_sreg <= alu_sreg;
            if (w_is_mul_wb) begin
               r_hold <= alu_mul_high;
            end
         end
      end
   end

   assign alu_a    = r_alu_a;
   assign alu_b    = r_alu_b;
   assign alu_fsel = r_alu_fsel;
   assign sreg     = r_sreg;
   assign retired  = r_retired;
   assign dbg_data = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: adder/multiplier ALU stub, transaction-level model with
// scheduled writebacks, per-cycle compare of every output and the whole register file.
`timescale 1ns/10ps
module tb_alu_issue_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [3:0] instr_func = '0;
   logic [2:0] instr_rs1 = '0;
   logic [2:0] instr_rs2 = '0;
   logic [2:0] instr_rd = '0;
   logic       instr_wb = 1'b0;
   logic       ld_valid = 1'b0;
   logic [2:0] ld_addr = '0;
   logic [7:0] ld_data = '0;
   logic [7:0] alu_a, alu_b;
   logic [3:0] alu_fsel;
   logic [7:0] alu_result, alu_mul_high;
   logic [3:0] alu_sreg;
   logic [3:0] sreg;
   logic       retired;
   logic [2:0] dbg_addr = '0;
   logic [7:0] dbg_data;

   alu_issue_unit #(.MUL_FUNC(4'd4), .REG_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_func(instr_func),
      .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd), .instr_wb(instr_wb),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fsel(alu_fsel),
      .alu_result(alu_result), .alu_mul_high(alu_mul_high), .alu_sreg(alu_sreg),
      .sreg(sreg), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // ALU stub: always adds; the multiplier high byte comes from A*B
   logic [8:0]  w_sum;
   logic [15:0] w_prod;
   assign w_sum        = {1'b0, alu_a} + {1'b0, alu_b};
   assign w_prod       = {8'b0, alu_a} * {8'b0, alu_b};
   assign alu_result   = w_sum[7:0];
   assign alu_mul_high = w_prod[15:8];
   assign alu_sreg     = {w_sum[8], (w_sum[7:0] == 8'd0), w_sum[7],
                          (alu_a[7] == alu_b[7]) && (w_sum[7] != alu_a[7])};

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   typedef struct {
      int         at_edge;
      bit         wr;
      logic [2:0] addr;
      logic [7:0] data;
      bit         upd;
      logic [3:0] sr;
      bit         last;
   } ev_t;

   ev_t        q[$];
   logic [7:0] m_rf [8];
   logic [3:0] m_sreg = '0;
   logic [7:0] m_a = '0, m_b = '0;
   logic [3:0] m_fsel = '0;
   bit         m_retired = 0;
   bit         m_last_acc = 0;
   int         m_acc_edge = 0;
   int         n_edge = 0;

   function automatic logic [3:0] add_flags(input int a, input int b);
      int s, sa, sb, ss;
      s  = a + b;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      ss = sa + sb;
      return {s > 255, (s % 256) == 0, (s % 256) > 127, (ss > 127) || (ss < -128)};
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
      m_sreg = '0; m_a = '0; m_b = '0; m_fsel = '0; m_retired = 0; m_last_acc = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock edge with the inputs currently driven; the model advances with it
   task automatic tick();
      bit         acc;
      bit         ret;
      int         a, b, sum;
      ev_t        e;
      acc = instr_valid && (q.size() == 0) && !ld_valid;
      a   = int'(m_rf[instr_rs1]);
      b   = int'(m_rf[instr_rs2]);
      @(posedge clk);
      n_edge++;
      ret = 0;
      if (ld_valid) m_rf[ld_addr] = ld_data;
      while (q.size() > 0 && q[0].at_edge == n_edge) begin
         e = q.pop_front();
         if (e.wr)   m_rf[e.addr] = e.data;
         if (e.upd)  m_sreg = e.sr;
         if (e.last) ret = 1;
      end
      m_retired  = ret;
      m_last_acc = acc;
      if (acc) begin
         m_acc_edge = n_edge;
         sum    = (a + b) % 256;
         m_a    = a[7:0];
         m_b    = b[7:0];
         m_fsel = instr_func;
         if (instr_wb && instr_func == 4'd4) begin
            q.push_back('{n_edge + 1, 1, instr_rd, sum[7:0], 1, add_flags(a, b), 0});
            q.push_back('{n_edge + 2, 1, instr_rd + 3'd1, 8'((a * b) / 256), 0, 4'd0, 1});
         end else begin
            q.push_back('{n_edge + 1, instr_wb, instr_rd, sum[7:0], 1, add_flags(a, b), 1});
         end
         $display("[TB] issue func=%0d rs1=%0d rs2=%0d rd=%0d wb=%0d A=%0d B=%0d",
                  instr_func, instr_rs1, instr_rs2, instr_rd, instr_wb, a, b);
      end
      #1;
   endtask

   // ---------------- compare process ----------------
   initial begin
      for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
      forever begin
         @(negedge clk);
         chk("instr_ready", instr_ready, (q.size() == 0) && !ld_valid);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_fsel", alu_fsel, m_fsel);
         chk("sreg", sreg, m_sreg);
         chk("retired", retired, m_retired);
         for (int i = 0; i < 8; i++) begin
            dbg_addr = i[2:0];
            #0.2;
            chk($sformatf("rf%0d", i), dbg_data, m_rf[i]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic load(input logic [2:0] addr, input logic [7:0] data);
      ld_valid = 1; ld_addr = addr; ld_data = data;
      tick();
      ld_valid = 0;
      $display("[TB] load r%0d=%0d", addr, data);
   endtask

   task automatic issue(input logic [3:0] f, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] d, input logic w, input bit keep);
      bit ok;
      instr_valid = 1; instr_func = f; instr_rs1 = s1; instr_rs2 = s2;
      instr_rd = d; instr_wb = w; ld_valid = 0;
      ok = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (m_last_acc) begin
            ok = 1;
            break;
         end
      end
      chk("issue_accept_timeout", ok, 1);
      if (!keep) instr_valid = 0;
   endtask

   task automatic idle(input int n);
      instr_valid = 0; ld_valid = 0;
      for (int k = 0; k < n; k++) tick();
   endtask

   int e1;

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      idle(2);

      // basic add
      load(3'd1, 8'd6);
      load(3'd2, 8'd9);
      issue(4'd1, 3'd1, 3'd2, 3'd3, 1'b1, 0);
      chk("add_opA", m_a, 8'd6);
      chk("add_opB", m_b, 8'd9);
      idle(3);
      chk("add_r3", m_rf[3], 8'd15);

      // multiply, high byte wraps to r0
      load(3'd0, 8'd200);
      load(3'd1, 8'd3);
      issue(4'd4, 3'd0, 3'd1, 3'd7, 1'b1, 0);
      tick();
      chk("mul_r7", m_rf[7], 8'd203);
      chk("mul_r0_pre", m_rf[0], 8'd200);
      chk("mul_sreg", m_sreg, 4'b0010);
      tick();
      chk("mul_r0_hi", m_rf[0], 8'h02);
      idle(2);

      // flags-only compare, also with the multiply code
      load(3'd4, 8'd127);
      load(3'd5, 8'd125);
      issue(4'd4, 3'd4, 3'd5, 3'd4, 1'b0, 0);
      idle(3);
      chk("cmp_r4", m_rf[4], 8'd127);
      chk("cmp_sreg", m_sreg, 4'b0011);

      // load blocks issue
      instr_valid = 1; instr_func = 4'd1; instr_rs1 = 3'd4; instr_rs2 = 3'd5; instr_rd = 3'd6; instr_wb = 1;
      for (int k = 0; k < 3; k++) begin
         ld_valid = 1; ld_addr = 3'(k); ld_data = 8'(8'h30 + k);
         tick();
         chk("ld_blocks_issue", m_last_acc, 0);
      end
      idle(1);

      // load collides with EXEC writeback to the same register
      load(3'd1, 8'd10);
      load(3'd2, 8'd20);
      issue(4'd1, 3'd1, 3'd2, 3'd3, 1'b1, 0);
      ld_valid = 1; ld_addr = 3'd3; ld_data = 8'hAA;
      tick();
      ld_valid = 0;
      idle(2);
      chk("collide_r3", m_rf[3], 8'd30);

      // back-to-back with a dependency
      issue(4'd1, 3'd1, 3'd2, 3'd5, 1'b1, 1);
      e1 = m_acc_edge;
      issue(4'd1, 3'd5, 3'd5, 3'd6, 1'b1, 0);
      chk("b2b_spacing", m_acc_edge - e1, 2);
      idle(3);
      chk("b2b_r5", m_rf[5], 8'd30);
      chk("b2b_r6", m_rf[6], 8'd60);

      // reset in the middle of EXEC
      load(3'd1, 8'd1);
      issue(4'd1, 3'd1, 3'd1, 3'd2, 1'b1, 0);
      #2 rst_n = 0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1;
      idle(3);
      chk("rst_r2", m_rf[2], 8'd0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         instr_valid = 1'($urandom_range(0, 1));
         instr_func  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) instr_func = 4'd4;
         instr_rs1   = 3'($urandom_range(0, 7));
         instr_rs2   = 3'($urandom_range(0, 7));
         instr_rd    = 3'($urandom_range(0, 7));
         instr_wb    = 1'($urandom_range(0, 3) != 0);
         ld_valid    = ($urandom_range(0, 3) == 0);
         ld_addr     = 3'($urandom_range(0, 7));
         ld_data     = 8'($urandom_range(0, 255));
         tick();
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Issue and writeback stage that sits directly in front of the ALU.
- Holds an 8x8-bit register file and reads the operands for each accepted instruction.
- Drives the ALU inputs A, B and function_select_lines from registered outputs.
- Captures the ALU result, the multiplier high byte and the 4-bit SREG, and writes them back to the register file and the status register.

Parameters:
- MUL_FUNC, 4'd4, function code whose high byte (mul_high) is also written back, to rd+1.
- REG_W, 8, data width of the operands and registers.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  unit can accept an instruction this cycle.
- instr_func  in  4  ALU function code.
- instr_rs1  in  3  source register for A.
- instr_rs2  in  3  source register for B.
- instr_rd  in  3  destination register.
- instr_wb  in  1  1 = write result to rd; 0 = update flags only (compare-style ops).
- ld_valid  in  1  direct register load strobe.
- ld_addr  in  3  load address.
- ld_data  in  REG_W  load data.
- alu_a  out  REG_W  ALU operand A, registered.
- alu_b  out  REG_W  ALU operand B, registered.
- alu_fsel  out  4  ALU function select, registered.
- alu_result  in  REG_W  ALU reg_out.
- alu_mul_high  in  REG_W  ALU mul_high.
- alu_sreg  in  4  ALU status flags.
- sreg  out  4  architectural status register.
- retired  out  1  one-cycle pulse when an instruction completes.
- dbg_addr  in  3  debug read address.
- dbg_data  out  REG_W  combinational read of rf[dbg_addr].

Behaviour:
- Reset (rst_n low, asynchronous): all 8 registers, sreg, alu_a, alu_b, alu_fsel, hold register and retired clear to 0; FSM goes to IDLE.
- Reset mid-operation aborts the instruction: no writeback, no retired pulse.
- FSM states and transitions:
  - IDLE -> EXEC on accept.
  - EXEC -> WB_HI if func==MUL_FUNC and wb=1; otherwise EXEC -> IDLE.
  - WB_HI -> IDLE.
- instr_ready = (state==IDLE) && !ld_valid. It is combinational, and a load always blocks issue in that cycle.
- Accept edge (instr_valid && instr_ready):
  - alu_a <= rf[rs1], alu_b <= rf[rs2], alu_fsel <= func.
  - Latch rd, wb and func.
  - rs1==rs2 is legal; both operands carry the same value.
- EXEC cycle: the ALU settles combinationally. At the closing edge:
  - sreg <= alu_sreg, always.
  - If wb: rf[rd] <= alu_result.
  - If MUL_FUNC and wb: hold <= alu_mul_high.
  - Otherwise retired pulses high in the following cycle.
- WB_HI edge:
  - rf[(rd+1) mod 8] <= hold; rd=7 wraps to r0.
  - sreg is unchanged.
  - retired pulses in the following cycle.
- Latency and throughput:
  - Non-multiply: result visible on dbg_data 2 edges after the accept edge (accept, EXEC close).
  - Multiply: the high byte is visible 1 edge later.
  - Throughput: one instruction per 2 cycles, or per 3 cycles for a multiply.
- alu_a, alu_b and alu_fsel hold their last values while idle; they change only on accept.
- Load port:
  - ld_valid writes rf[ld_addr] <= ld_data at the edge, in any state.
  - If a same-edge writeback targets the same address, the writeback wins and the load is dropped.
- All 8 registers are writable, r0 included; there is no hardwired zero.
- sreg is never written by loads.

Test Plan:
- Bench ALU stub: result = A+B (mod 256), mul_high = high byte of A*B, sreg = {C,Z,N,V} of the add.
- Reset/idle: rst_n low mid-EXEC of an add with rd=2 -> r2 stays 0, sreg=0, retired never pulses, instr_ready=1 after release.
- Basic add:
  - Stimulus: load r1=6, r2=9; issue func=1, rs1=1, rs2=2, rd=3, wb=1.
  - Response: alu_a=6, alu_b=9 the cycle after accept; r3=15 two edges after accept; retired pulses once; instr_ready low for 1 cycle.
- Multiply with wrap:
  - Stimulus: load r0=200, r1=3; issue func=MUL_FUNC, rs1=0, rs2=1, rd=7, wb=1.
  - Response: the stub's result byte goes to r7; hold=8'h02 (600=0x258); r0=0x02 one edge later; instr_ready low for 2 cycles; sreg updated only at EXEC close.
- Flags-only compare: load r4=127, r5=125; issue wb=0, rd=4 -> r4 stays 127, sreg updated, no WB_HI even when func=MUL_FUNC.
- Load/issue contention:
  - ld_valid held high while instr_valid is high -> instr_ready=0 and no issue.
  - A load to r3 on the same edge as an EXEC writeback to r3 -> r3 takes the ALU result.
- Back-to-back instructions: two adds with instr_valid held high -> accepts every 2nd cycle; the second instruction reads the first one's rd and gets the updated value.
